// File: rtl/micro_uart_rx_fifo_if.sv
// Receive-buffer bus between the micro UART receive FIFO and its users.
//   wr_data/wr_valid : byte and single-cycle strobe from the UART receiver
//   rd_req           : pop the head entry
//   rd_data          : head entry (first-word-fall-through), 8'h00 when empty
//   empty/full/level : registered occupancy status, level is 0..DEPTH
// master = producer/consumer side, slave = the FIFO itself.
interface micro_uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;

  modport master (
    output wr_data, wr_valid, rd_req,
    input  rd_data, empty, full, level
  );

  modport slave (
    input  wr_data, wr_valid, rd_req,
    output rd_data, empty, full, level
  );
endinterface

// File: rtl/micro_uart_rx_fifo.sv
// Receive FIFO behind the micro UART receiver. Captures each data_valid byte
// into a DEPTH-entry FIFO, presents it first-word-fall-through, flags overrun,
// and raises a registered interrupt on level threshold, character timeout
// (idle baud_mult16_ena ticks) or overrun.
//   clock, clock_sreset : clock and synchronous active-high reset
//   baud_mult16_ena     : 16x baud tick, drives the timeout counter
//   bus (slave)         : wr_data/wr_valid, rd_req, rd_data, empty, full, level
//   overrun             : sticky, a byte was dropped while full
//   timeout             : character-timeout flag
//   flush               : discard contents (wins over coincident read/write)
//   status_clear        : clears overrun
//   irq_ena / irq       : interrupt enable and registered interrupt
module micro_uart_rx_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned IRQ_LEVEL     = 8,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                 clock,
  input  logic                 clock_sreset,
  input  logic                 baud_mult16_ena,
  micro_uart_rx_fifo_if.slave  bus,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 flush,
  input  logic                 status_clear,
  input  logic                 irq_ena,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [PW-1:0] level_q, level_n;
  logic          empty_q, full_q, empty_n, full_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          timeout_n, overrun_n, irq_n;
  logic          do_wr, do_rd, ovr_event, cnt_clear;

  // A read while full frees the slot the coincident write lands in.
  assign do_rd     = bus.rd_req & ~empty_q;
  assign do_wr     = bus.wr_valid & (~full_q | bus.rd_req);
  assign ovr_event = bus.wr_valid & full_q & ~bus.rd_req & ~flush;
  assign cnt_clear = flush | do_wr | do_rd | empty_q;

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      if (do_wr) wr_ptr_n = wr_ptr + PW'(1);
      if (do_rd) rd_ptr_n = rd_ptr + PW'(1);
    end
    level_n = wr_ptr_n - rd_ptr_n;
    empty_n = (wr_ptr_n == rd_ptr_n);
    full_n  = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);

    cnt_n = cnt_q;
    if (cnt_clear)
      cnt_n = '0;
    else if (baud_mult16_ena && cnt_q != CW'(TIMEOUT_TICKS))
      cnt_n = cnt_q + CW'(1);
    timeout_n = ~cnt_clear & (cnt_n == CW'(TIMEOUT_TICKS));

    overrun_n = overrun;
    if (ovr_event)
      overrun_n = 1'b1;
    else if (status_clear)
      overrun_n = 1'b0;

    // Sources are the registered flags, so irq lags its cause by one cycle.
    irq_n = irq_ena & ((level_q >= PW'(IRQ_LEVEL)) | timeout | overrun);
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      timeout <= 1'b0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      level_q <= level_n;
      empty_q <= empty_n;
      full_q  <= full_n;
      cnt_q   <= cnt_n;
      timeout <= timeout_n;
      overrun <= overrun_n;
      irq     <= irq_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!clock_sreset && !flush && do_wr)
      mem[wr_ptr[AW-1:0]] <= bus.wr_data;
  end

  assign bus.rd_data = empty_q ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.empty   = empty_q;
  assign bus.full    = full_q;
  assign bus.level   = level_q;

endmodule

// File: tb/tb_micro_uart_rx_fifo.sv
module tb_micro_uart_rx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IRQ_LEVEL = 8;
  localparam int unsigned TIMEOUT_TICKS = 640;

  logic clock = 1'b0;
  logic clock_sreset, baud_mult16_ena, flush, status_clear, irq_ena;
  logic overrun, timeout, irq;

  micro_uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  micro_uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clock(clock), .clock_sreset(clock_sreset), .baud_mult16_ena(baud_mult16_ena),
    .bus(bus), .overrun(overrun), .timeout(timeout), .flush(flush),
    .status_clear(status_clear), .irq_ena(irq_ena), .irq(irq)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: a byte queue plus flag bits and a tick count.
  logic [7:0] q[$];
  bit m_ovr, m_to, m_irq;
  int m_cnt;
  logic ena = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, wv, input logic [7:0] wd, input logic rr, fl, sc, tk, en);
    int n;
    bit irq_next, rd_done, wr_ok, ev;
    if (r) begin
      q.delete(); m_ovr = 0; m_to = 0; m_cnt = 0; m_irq = 0;
      return;
    end
    n = q.size();
    irq_next = en && (n >= IRQ_LEVEL || m_to || m_ovr);
    if (fl) begin
      q.delete(); m_cnt = 0; m_to = 0;
      if (sc) m_ovr = 0;
    end else begin
      rd_done = rr && n > 0;
      wr_ok   = wv && (n < DEPTH || rr);
      ev      = wv && n == DEPTH && !rr;
      if (rd_done) void'(q.pop_front());
      if (wr_ok) q.push_back(wd);
      if (ev) m_ovr = 1; else if (sc) m_ovr = 0;
      if (wr_ok || rd_done || n == 0) begin
        m_cnt = 0; m_to = 0;
      end else if (tk) begin
        if (m_cnt < TIMEOUT_TICKS) m_cnt++;
        m_to = (m_cnt == TIMEOUT_TICKS);
      end
    end
    m_irq = irq_next;
  endtask

  task automatic cycle(input logic r, wv, input logic [7:0] wd, input logic rr, fl, sc, tk);
    clock_sreset = r; bus.wr_valid = wv; bus.wr_data = wd; bus.rd_req = rr;
    flush = fl; status_clear = sc; baud_mult16_ena = tk; irq_ena = ena;
    @(posedge clock);
    model(r, wv, wd, rr, fl, sc, tk, ena);
    #1;
    chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("m_level", 32'(bus.level), 32'(q.size()));
    chk("m_rd_data", 32'(bus.rd_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("m_overrun", 32'(overrun), 32'(m_ovr));
    chk("m_timeout", 32'(timeout), 32'(m_to));
    chk("m_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [7:0] d); cycle(0, 1, d, 0, 0, 0, 0); endtask
  task automatic rd();                   cycle(0, 0, 8'h00, 1, 0, 0, 0); endtask
  task automatic idle();                 cycle(0, 0, 8'h00, 0, 0, 0, 0); endtask

  task automatic chk_reset_vals();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_irq", 32'(irq), 0);
  endtask

  initial begin
    // Reset
    cycle(1, 0, 8'h00, 0, 0, 0, 0);
    cycle(1, 0, 8'h00, 0, 0, 0, 0);
    chk_reset_vals();

    // Single byte, first-word-fall-through
    wr(8'hA5);
    chk("fwft_empty", 32'(bus.empty), 0);
    chk("fwft_level", 32'(bus.level), 1);
    chk("fwft_data", 32'(bus.rd_data), 32'hA5);
    rd();
    chk("pop_empty", 32'(bus.empty), 1);
    chk("pop_data", 32'(bus.rd_data), 0);

    // Fill, overrun, drain in order, clear
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_level", 32'(bus.level), 16);
    wr(8'hFF);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_level", 32'(bus.level), 16);
    for (int i = 0; i < 16; i++) begin
      chk("order", 32'(bus.rd_data), 32'(i));
      rd();
    end
    chk("drained", 32'(bus.empty), 1);
    cycle(0, 0, 8'h00, 0, 0, 1, 0);
    chk("ovr_clear", 32'(overrun), 0);

    // Simultaneous read/write while full
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    cycle(0, 1, 8'h55, 1, 0, 0, 0);
    chk("rw_full_level", 32'(bus.level), 16);
    chk("rw_full_ovr", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("rw_full_last", 32'(bus.rd_data), 32'h55);
      rd();
    end

    // Level threshold interrupt
    ena = 1'b1;
    for (int i = 0; i < 7; i++) wr(8'(8'h20 + i));
    idle();
    chk("irq_lvl7", 32'(irq), 0);
    wr(8'h27);
    chk("irq_lag", 32'(irq), 0);
    idle();
    chk("irq_lvl8", 32'(irq), 1);
    rd();
    idle();
    chk("irq_drop7", 32'(irq), 0);
    for (int i = 0; i < 7; i++) rd();

    // Character timeout
    for (int i = 0; i < 3; i++) wr(8'(8'h30 + i));
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) begin
      cycle(0, 0, 8'h00, 0, 0, 0, 1);
      idle();
    end
    chk("to_before", 32'(timeout), 0);
    cycle(0, 0, 8'h00, 0, 0, 0, 1);
    chk("to_set", 32'(timeout), 1);
    idle();
    chk("to_irq", 32'(irq), 1);
    rd();
    chk("to_clr", 32'(timeout), 0);
    idle();
    chk("to_irq_drop", 32'(irq), 0);

    // Flush with coincident write
    for (int i = 0; i < 3; i++) wr(8'(8'h40 + i));
    chk("pre_flush_lvl", 32'(bus.level), 5);
    cycle(0, 1, 8'h77, 0, 1, 0, 0);
    chk("flush_level", 32'(bus.level), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_ovr", 32'(overrun), 0);

    // Reset mid-operation
    for (int i = 0; i < 10; i++) wr(8'(8'h50 + i));
    idle();
    chk("pre_rst_irq", 32'(irq), 1);
    cycle(1, 1, 8'h99, 1, 0, 0, 0);
    chk_reset_vals();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) ena = ~ena;
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 50,
            8'($urandom),
            $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/micro_uart_rx_fifo.md
Name: micro_uart_rx_fifo

Overview:
Receive buffer directly downstream of the micro UART receiver. It captures each byte the receiver delivers on its single-cycle data_valid pulse into a DEPTH-entry FIFO and presents the bytes first-word-fall-through to the Forth micro's peripheral read logic. It flags overrun and generates a combined interrupt from three sources: level threshold, idle-line character timeout (counted in the receiver's baud_mult16_ena ticks) and overrun.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256.
IRQ_LEVEL, 8, level at or above which the threshold interrupt is asserted; 1..DEPTH.
TIMEOUT_TICKS, 640, baud_mult16_ena ticks (4 characters x 10 bits x 16) of inactivity before the timeout flag sets.

Ports:
clock  input  1  system clock
clock_sreset  input  1  synchronous active-high reset
baud_mult16_ena  input  1  16x baud tick from the receiver
wr_data  input  8  received byte (receiver data_out)
wr_valid  input  1  write strobe (receiver data_valid); one write per high cycle
rd_req  input  1  pop the head entry
rd_data  output  8  head entry; 8'h00 when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because the FIFO was full
timeout  output  1  character-timeout flag
flush  input  1  discard all contents
status_clear  input  1  clears overrun
irq_ena  input  1  interrupt enable
irq  output  1  registered interrupt

Behaviour:
- Reset (clock_sreset=1): write and read pointers 0, level 0, empty 1, full 0, overrun 0, timeout 0, irq 0, rd_data 8'h00. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. Pointers wrap naturally with no explicit compare against DEPTH.
- empty and full are registered and change in the same cycle as level. The rules below define behaviour with respect to the pre-edge state.
- Write: wr_valid=1 and full=0 stores wr_data at the write pointer, increments the pointer, and level increments by 1.
- Write while full: byte dropped, overrun<=1, pointers unchanged.
- Read: rd_req=1 and empty=0 advances the read pointer, and level decrements by 1. rd_req while empty is ignored with no error.
- rd_data is first-word-fall-through. A byte written at edge N is visible on rd_data after edge N (latency 1) when the FIFO was empty.
- Simultaneous read and write while not empty and not full: both are performed and level is unchanged.
- Simultaneous read and write while full: the read is performed, the write is accepted into the freed slot, level stays DEPTH, and there is no overrun.
- Simultaneous read and write while empty: the write is accepted, the read is ignored, and level becomes 1.
- flush=1:
  - Pointers and level go to 0, empty goes to 1, full goes to 0, timeout goes to 0, and the timeout counter goes to 0.
  - flush has priority over a coincident write or read. The coincident byte is discarded and does not set overrun.
  - overrun is not affected by flush.
- status_clear=1 clears overrun. A coincident overrun event wins and overrun stays 1.
- Timeout counter:
  - Width is $clog2(TIMEOUT_TICKS+1).
  - It is cleared on any accepted write, any performed read, flush, or while empty=1.
  - Otherwise it increments on each baud_mult16_ena=1 cycle and saturates at TIMEOUT_TICKS.
  - timeout<=1 on the cycle the counter reaches TIMEOUT_TICKS. timeout<=0 on any clear condition.
- irq is registered: irq <= irq_ena & ((level >= IRQ_LEVEL) | timeout | overrun), evaluated on the post-update flag values. It therefore asserts one cycle after the causing flag changes.
- irq deasserts one cycle after all of its sources clear or irq_ena drops.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight write or read is lost.
- No state machine beyond pointer, level and counter registers. All outputs are registered except rd_data, which is a combinational memory read gated by empty.

Test Plan:
- Reset, then write 8'hA5 -> next cycle empty=0, level=1, rd_data=8'hA5. Then assert rd_req for 1 cycle -> empty=1, level=0, rd_data=8'h00.
- Write 0x00..0x0F (DEPTH=16) -> full=1, level=16. Write 8'hFF -> overrun=1 and the FIFO is unchanged. Read all 16 bytes -> data in order 0x00..0x0F. Assert status_clear -> overrun=0.
- Full FIFO, rd_req and wr_valid (8'h55) in the same cycle -> level stays 16, no overrun, 8'h55 is read last.
- irq_ena=1, IRQ_LEVEL=8 -> irq=0 after 7 writes. irq=1 one cycle after the 8th write. irq=0 one cycle after the level drops to 7.
- 3 bytes written, then 640 baud_mult16_ena ticks with no traffic -> timeout=1 and irq=1 next cycle. A read clears timeout, and irq drops one cycle later.
- Level 5 with flush and wr_valid in the same cycle -> level=0, empty=1, overrun unchanged. Assert clock_sreset while level is 10 -> all outputs return to their reset values.
